// File: rtl/wave_mem_reader_if.sv
// wave_mem_reader_if: command, RAM read port and sample stream of the
// waveform RAM readback engine, bundled so host, RAM and engine share one bus.
interface wave_mem_reader_if #(
    parameter int DATA_LEN    = 8,
    parameter int ROWS_BASE_2 = 8
);
    logic                   start;
    logic                   abort;
    logic [ROWS_BASE_2-1:0] base_addr;
    logic [ROWS_BASE_2:0]   length;
    logic                   rd_en;
    logic [ROWS_BASE_2-1:0] rd_addr;
    logic [DATA_LEN-1:0]    rd_data;
    logic [DATA_LEN-1:0]    dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, base_addr, length, rd_data, dout_ready,
        input  rd_en, rd_addr, dout, dout_valid, busy, done
    );

    modport slave (
        input  start, abort, base_addr, length, rd_data, dout_ready,
        output rd_en, rd_addr, dout, dout_valid, busy, done
    );
endinterface

// File: rtl/wave_mem_reader.sv
// wave_mem_reader: reads a burst of words out of the synchronous-read DDS
// waveform RAM and streams them on a valid/ready output with backpressure.
// A 2-entry FIFO plus a one-deep in-flight flag absorbs the RAM's one-cycle
// read latency, so a returned word always has a slot to land in.
module wave_mem_reader #(
    parameter int DATA_LEN    = 8,
    parameter int ROWS_BASE_2 = 8
) (
    input  logic             src_clk,
    input  logic             rst_n,
    wave_mem_reader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ROWS_BASE_2-1:0] ADDR_ONE = {{(ROWS_BASE_2-1){1'b0}}, 1'b1};
    localparam logic [ROWS_BASE_2:0]   REM_ONE  = {{ROWS_BASE_2{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [ROWS_BASE_2-1:0] addr_q, addr_d;
    logic [ROWS_BASE_2:0]   remaining_q, remaining_d;
    logic [DATA_LEN-1:0]    fifo_mem [0:1];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             fifo_count_q;
    logic                   inflight_q;
    logic                   zero_done_q;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic                   last_xfer;

    assign pop       = (fifo_count_q != 2'd0) && bus.dout_ready;
    assign push      = inflight_q;
    assign issue     = (state_q == READ) && !bus.abort && (remaining_q != '0) &&
                       ((({1'b0, fifo_count_q} + {2'b00, inflight_q}) < 3'd2) || pop);
    assign last_xfer = (state_q == DRAIN) && !bus.abort && pop &&
                       (fifo_count_q == 2'd1) && !inflight_q;

    assign bus.rd_en      = issue;
    assign bus.rd_addr    = addr_q;
    assign bus.dout       = fifo_mem[rd_ptr_q];
    assign bus.dout_valid = (fifo_count_q != 2'd0);
    assign bus.busy       = (state_q != IDLE) && !last_xfer;
    assign bus.done       = zero_done_q || last_xfer;

    // Next-state and burst counters: abort wins, start only counts in IDLE
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_d      = bus.base_addr;
                        remaining_d = bus.length;
                        if (bus.length != '0) begin
                            state_d = READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_d      = addr_q + ADDR_ONE;
                        remaining_d = remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_d = DRAIN;
                        end
                    end else if (remaining_q == '0) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_xfer) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, address and remaining-count registers
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Return FIFO and in-flight flag; abort drops both, including a pending read
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
            inflight_q   <= 1'b0;
        end else if (bus.abort) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= bus.rd_data;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                fifo_count_q <= fifo_count_q + 2'd1;
            end else if (!push && pop) begin
                fifo_count_q <= fifo_count_q - 2'd1;
            end
            inflight_q <= issue;
        end
    end

    // A zero-length start finishes immediately: done pulses one cycle later
    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= (state_q == IDLE) && bus.start && !bus.abort &&
                           (bus.length == '0);
        end
    end
endmodule

// File: tb/tb_wave_mem_reader.sv
// tb_wave_mem_reader: drives wave_mem_reader with directed and random bursts
// against a RAM model, and checks every cycle against a burst-level model.
`timescale 1ns/1ps
module tb_wave_mem_reader;
    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic src_clk = 1'b0;
    logic rst_n;

    wave_mem_reader_if #(.DATA_LEN(DW), .ROWS_BASE_2(AW)) bus ();

    wave_mem_reader #(.DATA_LEN(DW), .ROWS_BASE_2(AW)) dut (
        .src_clk (src_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    // Free-running 100 MHz clock
    always #5 src_clk = ~src_clk;

    logic [DW-1:0] ram [DEPTH];

    // Synchronous-read waveform RAM: data appears the cycle after rd_en
    always @(posedge src_clk) begin
        if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Burst-level model: expected words, reads issued, words transferred
    bit            m_active;
    bit            m_zero_pending;
    bit            m_prev_stall;
    logic [DW-1:0] m_prev_dout;
    int            m_len;
    int            m_reads;
    int            m_xfers;
    int            m_base;
    logic [DW-1:0] m_words [$];
    logic          cmp_xfer;
    logic          cmp_drain_done;
    bit            cmp_prev_active;

    logic [DW-1:0] got [$];
    bit            pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit st, input bit ab, input int base,
                                 input int len, input bit rdy);
        bus.start      = st;
        bus.abort      = ab;
        bus.base_addr  = base[AW-1:0];
        bus.length     = len[AW:0];
        bus.dout_ready = rdy;
    endtask

    task automatic nextCycle();
        @(posedge src_clk);
        #1;
    endtask

    // mode 0: ready high, 1: fixed toggle pattern, 2: random ready and
    // ignored starts, 3: as 2 plus occasional abort
    task automatic runBurst(input int base, input int len, input int mode);
        int c;
        got.delete();
        applyStimulus(1, 0, base, len, 1);
        nextCycle();
        applyStimulus(0, 0, base, len, 1);
        c = 0;
        while ((m_active || m_zero_pending) && c < 3000) begin
            case (mode)
                0:       bus.dout_ready = 1'b1;
                1:       bus.dout_ready = pat[c % 12];
                default: bus.dout_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode >= 2) begin
                bus.start     = m_active && ($urandom_range(0, 15) == 0);
                bus.base_addr = AW'($urandom);
                bus.length    = (AW+1)'($urandom_range(1, 20));
            end
            if (mode == 3) bus.abort = ($urandom_range(0, 39) == 0);
            @(negedge src_clk);
            if (bus.dout_valid && bus.dout_ready) got.push_back(bus.dout);
            nextCycle();
            c++;
        end
        n_checks++;
        if (m_active || m_zero_pending) begin
            n_fail++;
            $display("[TB] FAIL burst_timeout actual=busy required=idle base=%0d len=%0d", base, len);
        end
        applyStimulus(0, 0, 0, 0, 1);
    endtask

    task automatic checkGot(input string name, input int first, input int n);
        checkOutput({name, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            checkOutput(name, got[i], (first + i) & 8'hFF);
        end
    endtask

    // Per-cycle compare against the burst-level model
    always @(negedge src_clk) begin
        if (!rst_n) begin
            m_active       = 1'b0;
            m_zero_pending = 1'b0;
            m_prev_stall   = 1'b0;
            m_words.delete();
        end else begin
            cmp_xfer       = bus.dout_valid && bus.dout_ready;
            cmp_drain_done = m_active && cmp_xfer && (m_xfers == m_len - 1) && !bus.abort;
            checkOutput("done", bus.done, m_zero_pending || cmp_drain_done);
            checkOutput("busy", bus.busy, m_active && !cmp_drain_done);
            if (!m_active) begin
                checkOutput("valid_idle", bus.dout_valid, 0);
                if (!bus.abort) checkOutput("rd_en_idle", bus.rd_en, 0);
            end
            if (m_prev_stall) begin
                checkOutput("hold_valid", bus.dout_valid, 1);
                checkOutput("hold_dout", bus.dout, m_prev_dout);
            end
            if (cmp_xfer && m_active) begin
                if (m_words.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL extra_word actual=%0d required=none", bus.dout);
                end else begin
                    checkOutput("dout", bus.dout, m_words.pop_front());
                    m_xfers++;
                end
            end
            if (m_active && !bus.abort) begin
                if (bus.rd_en) begin
                    checkOutput("read_count_le_len", (m_reads < m_len), 1);
                    checkOutput("rd_addr", bus.rd_addr, (m_base + m_reads) % DEPTH);
                    m_reads++;
                end
                checkOutput("in_flight_bound", (m_reads - m_xfers <= 3), 1);
            end
            m_prev_stall    = bus.dout_valid && !bus.dout_ready && !bus.abort;
            m_prev_dout     = bus.dout;
            cmp_prev_active = m_active;
            m_zero_pending  = 1'b0;
            if (bus.abort) begin
                m_active = 1'b0;
                m_words.delete();
            end else begin
                if (cmp_drain_done) m_active = 1'b0;
                if (!cmp_prev_active && bus.start) begin
                    if (bus.length == '0) begin
                        m_zero_pending = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_len    = int'(bus.length);
                        m_base   = int'(bus.base_addr);
                        m_reads  = 0;
                        m_xfers  = 0;
                        m_words.delete();
                        for (int i = 0; i < m_len; i++) m_words.push_back(ram[(m_base + i) % DEPTH]);
                    end
                end
            end
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by random bursts
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 1);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 1);
        #2;
        checkOutput("reset_rd_en", bus.rd_en, 0);
        checkOutput("reset_rd_addr", bus.rd_addr, 0);
        checkOutput("reset_dout", bus.dout, 0);
        checkOutput("reset_valid", bus.dout_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        repeat (2) @(posedge src_clk);
        #1 rst_n = 1'b1;
        nextCycle();

        // Basic burst with exact cycle timing
        applyStimulus(1, 0, 10, 4, 1);
        nextCycle();
        applyStimulus(0, 0, 10, 4, 1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge src_clk);
            checkOutput("basic_rd_en", bus.rd_en, (k <= 4));
            if (k <= 4) checkOutput("basic_rd_addr", bus.rd_addr, 9 + k);
            checkOutput("basic_valid", bus.dout_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) checkOutput("basic_dout", bus.dout, 8 + k);
            checkOutput("basic_done", bus.done, (k == 6));
            checkOutput("basic_busy", bus.busy, (k <= 5));
            nextCycle();
        end

        // Zero length: done one cycle after start, never busy
        applyStimulus(1, 0, 5, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 5, 0, 1);
        @(negedge src_clk);
        checkOutput("zero_done", bus.done, 1);
        checkOutput("zero_busy", bus.busy, 0);
        checkOutput("zero_rd_en", bus.rd_en, 0);
        nextCycle();
        @(negedge src_clk);
        checkOutput("zero_done_once", bus.done, 0);
        nextCycle();

        runBurst(10, 4, 1);
        checkGot("backpressure", 11, 4);
        runBurst(254, 4, 0);
        checkGot("wrap", 255, 4);
        runBurst(0, 256, 2);
        checkGot("full_depth", 1, 256);

        // Abort at word 4 after an ignored restart at word 2
        applyStimulus(1, 0, 20, 8, 1);
        nextCycle();
        applyStimulus(0, 0, 20, 8, 1);
        nextCycle();
        nextCycle();
        nextCycle();
        applyStimulus(1, 0, 100, 3, 1);
        nextCycle();
        applyStimulus(0, 0, 20, 8, 1);
        nextCycle();
        applyStimulus(0, 1, 20, 8, 1);
        @(negedge src_clk);
        checkOutput("abort_cycle_done", bus.done, 0);
        nextCycle();
        applyStimulus(0, 0, 20, 8, 1);
        for (int j = 0; j < 5; j++) begin
            @(negedge src_clk);
            checkOutput("post_abort_busy", bus.busy, 0);
            checkOutput("post_abort_valid", bus.dout_valid, 0);
            checkOutput("post_abort_rd_en", bus.rd_en, 0);
            checkOutput("post_abort_done", bus.done, 0);
            nextCycle();
        end
        runBurst(30, 8, 0);
        checkGot("after_abort", 31, 8);

        // Asynchronous reset in the middle of a burst
        applyStimulus(1, 0, 40, 30, 1);
        nextCycle();
        applyStimulus(0, 0, 40, 30, 1);
        nextCycle();
        nextCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_rd_en", bus.rd_en, 0);
        checkOutput("midrst_rd_addr", bus.rd_addr, 0);
        checkOutput("midrst_dout", bus.dout, 0);
        checkOutput("midrst_valid", bus.dout_valid, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        @(posedge src_clk);
        #2 rst_n = 1'b1;
        nextCycle();
        runBurst(50, 5, 0);
        checkGot("after_reset", 51, 5);

        // Random contents, bases, lengths, backpressure and aborts
        for (int b = 0; b < 16; b++) begin
            int r;
            int len;
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      len = 0;
            else if (r == 1) len = 256;
            else             len = $urandom_range(1, 40);
            runBurst($urandom_range(0, 255), len, (b % 4 == 3) ? 3 : 2);
            nextCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wave_mem_reader.md
Name: wave_mem_reader

Overview:
- Readback engine for the DDS waveform RAM. The write side is data_wr/addr_wr/we; this block is the read side.
- On a start command it reads a burst of words from the synchronous-read waveform RAM, from a base address for a given length.
- Samples leave on a valid/ready stream with full backpressure support, for verification dumps and host readback of the loaded signal.
- Runs in the src_clk domain alongside the DDS core.

Parameters:
DATA_LEN, 8, width of one waveform sample / RAM word
ROWS_BASE_2, 8, RAM address width; depth = 2**ROWS_BASE_2

Ports:
src_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle burst request, sampled only in IDLE
abort  input  1  cancel current burst, any state
base_addr  input  ROWS_BASE_2  first RAM address of burst, captured on accepted start
length  input  ROWS_BASE_2+1  word count, 0..2**ROWS_BASE_2, captured on accepted start
rd_en  output  1  RAM read strobe
rd_addr  output  ROWS_BASE_2  RAM read address
rd_data  input  DATA_LEN  RAM read data, valid the cycle after rd_en
dout  output  DATA_LEN  stream sample
dout_valid  output  1  stream sample valid
dout_ready  input  1  stream sink ready
busy  output  1  high from accepted start until done/abort
done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (rst_n low, async): state IDLE, FIFO empty, in-flight flag clear. All outputs 0 (rd_en, rd_addr, dout, dout_valid, busy, done).
- States: IDLE, READ, DRAIN.
- IDLE: start=1 captures base_addr into the address counter and length into the remaining counter.
  - length!=0: go to READ; busy=1 from the next cycle.
  - length==0: stay in IDLE, pulse done the next cycle, busy stays 0, no rd_en.
- READ: rd_en=1 when remaining!=0 and either (fifo_count+inflight)<2 or a pop (dout_valid&&dout_ready) occurs this cycle.
  - rd_addr = address counter, combinational from the registers.
  - Each rd_en increments the address modulo 2**ROWS_BASE_2 (wraps 2**ROWS_BASE_2-1 -> 0) and decrements remaining.
  - Go to DRAIN once remaining reaches 0.
- Read latency: rd_en in cycle N -> rd_data sampled at the end of N+1 into a 2-entry FIFO -> dout_valid no earlier than N+2. inflight is a 1-bit flag for a read issued last cycle.
- Throughput: one word per cycle with dout_ready held high. The 2-entry FIFO is sized so no returned word is ever dropped under any dout_ready pattern.
- Stream rules:
  - dout = FIFO head.
  - dout_valid = FIFO not empty.
  - Once valid, dout and dout_valid hold stable until accepted.
  - Transfer occurs when dout_valid&&dout_ready.
  - Simultaneous FIFO write and pop is legal.
- DRAIN: no reads issued. When the last word transfers (FIFO empty, no inflight after the pop): pulse done for 1 cycle, drop busy in the same cycle, return to IDLE.
- start while busy: ignored, no effect on the burst.
- abort (highest priority, checked before start):
  - Next cycle: state IDLE, FIFO flushed, dout_valid=0, busy=0, done not pulsed.
  - A read still in flight is discarded.
  - start and abort together in IDLE: start ignored.
- Output words appear in address order; the RAM contents are never modified.

Test Plan:
- Basic burst: RAM[i]=i+1, ROWS_BASE_2=8, base=10, length=4, dout_ready=1, start at edge E -> rd_addr 10,11,12,13 in cycles E+1..E+4; dout 11,12,13,14 valid in cycles E+3..E+6; done pulses in cycle E+6 and busy falls in the same cycle.
- Backpressure: same burst with dout_ready toggling 1,0,0,1,0,1... -> dout sequence still exactly 11,12,13,14, no duplicates or drops, dout stable while ready=0, fifo_count never exceeds 2, done only after the 4th transfer.
- Wrap-around: base=254, length=4 -> rd_addr 254,255,0,1; dout = RAM[254],RAM[255],RAM[0],RAM[1].
- Boundary lengths: length=0 -> no rd_en, done pulse 1 cycle after start, busy stays 0. length=256, base=0 -> 256 words from address 0 through 255, then done.
- Abort/start-while-busy: start length=8, pulse start again at word 2 (ignored), assert abort at word 4 -> busy/dout_valid low next cycle, no done, no further rd_en. A fresh start then delivers a correct full burst.
- Reset mid-burst: drop rst_n asynchronously between clock edges during READ -> all outputs 0 immediately; after release the block is IDLE and accepts a new start.
